mask_health_ctrl: RTL and testbench
===================================

# mask_health_ctrl

Knight health and soul controller for the HUD mask row. It consumes per-frame combat events (damage taken, hits landed, focus held) and tracks the mask count, the soul meter, invulnerability frames, the focus-heal sequence and the death/respawn cycle. It produces the per-mask visibility vector that the HUD sprite logic gates against the fixed mask icon positions. It also exposes status flags to the knight controller.

## Interface
- MAX_MASKS, 5: full health, and width of mask_on
- INVULN_FRAMES, 60: post-hit and post-respawn invulnerability length
- HEAL_FRAMES, 45: frames focus must be held to restore one mask
- SOUL_MAX, 99: soul saturation value
- SOUL_COST, 33: soul consumed per completed heal
- SOUL_PER_HIT, 11: soul gained per hit_dealt
- DEATH_FRAMES, 120: frames spent in death before respawn

- frame_clk  in  1  frame-rate clock; sole clock
- Reset  in  1  synchronous, active-high
- hit_taken  in  1  one-frame pulse: knight damaged
- hit_dealt  in  1  one-frame pulse: knight struck an enemy
- focus_hold  in  1  level: focus button held
- mask_count  out  3  current masks, 0..MAX_MASKS
- mask_on  out  MAX_MASKS  bit i = (i < mask_count)
- soul  out  7  soul meter, 0..SOUL_MAX
- invuln  out  1  invulnerability timer nonzero
- blink  out  1  invuln & invuln_timer[2]; HUD and knight flicker
- healing  out  1  state == FOCUS
- dead  out  1  state == DEAD
- respawn  out  1  one-frame pulse on DEAD→ALIVE

## Operation
- States: ALIVE, FOCUS, DEAD. Reset (synchronous, priority over all) → ALIVE, mask_count=MAX_MASKS, soul=0, all timers 0, respawn=0.
- ALIVE:
  - hit_taken with invuln=0: mask_count−1 and invuln_timer=INVULN_FRAMES.
  - If mask_count was 1: → DEAD, death_timer=DEATH_FRAMES, invuln_timer=0.
  - hit_taken with invuln=1: ignored.
  - Enter FOCUS, focus_cnt=0, when all hold: focus_hold=1, soul≥SOUL_COST, mask_count<MAX_MASKS, invuln=0, hit_taken=0.
- FOCUS:
  - focus_cnt increments each frame.
  - hit_taken: damage applied exactly as in ALIVE, focus aborted, no soul spent, → ALIVE, or → DEAD if this was the last mask.
  - focus_hold=0: → ALIVE, no change.
  - focus_cnt==HEAL_FRAMES−1 with hold still present: mask_count+1, soul−=SOUL_COST, → ALIVE.
  - Precedence: hit_taken > release > completion.
- DEAD:
  - death_timer decrements; hit_taken, hit_dealt and focus_hold are ignored.
  - At death_timer==1: → ALIVE, mask_count=MAX_MASKS, soul=0, invuln_timer=INVULN_FRAMES, respawn=1 for that frame.
- Soul:
  - hit_dealt in ALIVE or FOCUS adds SOUL_PER_HIT.
  - Computed in 8 bits, saturates at SOUL_MAX, never underflows.
  - Heal completion together with hit_dealt: soul = min(soul−SOUL_COST+SOUL_PER_HIT, SOUL_MAX).
- invuln_timer decrements to 0 in every state except DEAD.
- A hit on the same frame invuln_timer reaches 0 is ignored. invuln reflects the registered pre-decrement value.

## Timing
- All state, counters and outputs are registered. Events sampled on frame N are visible on outputs at frame N+1.
- mask_on is combinational from the registered mask_count; it has no extra latency.
- After a hit, the next hit is accepted exactly INVULN_FRAMES frames later.
- A heal completes HEAL_FRAMES frames after FOCUS entry.
- Respawn occurs DEATH_FRAMES frames after entering DEAD.
- mask_count never exceeds MAX_MASKS and never wraps below 0.
- Reset asserted mid-FOCUS or mid-DEAD: the next frame shows the reset values, and no respawn pulse is produced.

## Structure
- Package hk_health_pkg: state enum (ALIVE, FOCUS, DEAD) and default constants. Shared with the knight controller and the HUD renderer.
- One sub-module, frame_timer: a loadable down-counter with a zero flag. Instantiated for invulnerability and for death.
- The focus up-counter stays inline.

## Test plan
- Reset, then 5 hit_taken pulses spaced 61 frames apart → mask_count 5,4,3,2,1,0; dead=1 after the 5th; respawn pulse 120 frames later with mask_count=5, soul=0, invuln=1.
- hit_taken on frames 0 and 30 → a single decrement; a hit at frame 60 is accepted (mask_count 5→3 overall).
- 3 hit_dealt pulses → soul=33; hit once, wait out invuln; hold focus for 45 frames → mask_count 4→5, soul=0, healing drops.
- Soul at 33, one mask lost, focus held for 20 frames, then release → no heal, soul=33. Repeat, but with hit_taken at frame 20 → mask_count−1, soul unchanged, state ALIVE.
- 10 hit_dealt pulses → soul saturates at 99. Heal completion coinciding with hit_dealt from soul 99 → 77.
- Reset asserted at death_timer=50 → ALIVE, mask_count=5, dead=0, no respawn pulse.

Source files
------------

// File: rtl/hk_health_pkg.sv
// Shared health/soul definitions for the knight controller, the HUD renderer
// and mask_health_ctrl.
package hk_health_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        FOCUS = 2'd1,
        DEAD  = 2'd2
    } health_state_t;

    localparam int unsigned HK_MAX_MASKS     = 5;
    localparam int unsigned HK_INVULN_FRAMES = 60;
    localparam int unsigned HK_HEAL_FRAMES   = 45;
    localparam int unsigned HK_SOUL_MAX      = 99;
    localparam int unsigned HK_SOUL_COST     = 33;
    localparam int unsigned HK_SOUL_PER_HIT  = 11;
    localparam int unsigned HK_DEATH_FRAMES  = 120;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter that stops at zero; load wins over decrement.
module frame_timer #(
    parameter int unsigned W = 8
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mask_health_ctrl.sv
// Knight mask/soul controller: damage, invulnerability, focus heal and the
// death/respawn cycle, plus the HUD mask visibility vector.
module mask_health_ctrl
    import hk_health_pkg::*;
#(
    parameter int unsigned MAX_MASKS     = HK_MAX_MASKS,
    parameter int unsigned INVULN_FRAMES = HK_INVULN_FRAMES,
    parameter int unsigned HEAL_FRAMES   = HK_HEAL_FRAMES,
    parameter int unsigned SOUL_MAX      = HK_SOUL_MAX,
    parameter int unsigned SOUL_COST     = HK_SOUL_COST,
    parameter int unsigned SOUL_PER_HIT  = HK_SOUL_PER_HIT,
    parameter int unsigned DEATH_FRAMES  = HK_DEATH_FRAMES
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 hit_taken,
    input  logic                 hit_dealt,
    input  logic                 focus_hold,
    output logic [2:0]           mask_count,
    output logic [MAX_MASKS-1:0] mask_on,
    output logic [6:0]           soul,
    output logic                 invuln,
    output logic                 blink,
    output logic                 healing,
    output logic                 dead,
    output logic                 respawn
);

    localparam int unsigned INV_RAW = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned INV_W   = (INV_RAW < 3) ? 3 : INV_RAW;
    localparam int unsigned DTH_W   = $clog2(DEATH_FRAMES + 1);
    localparam int unsigned FOC_W   = $clog2(HEAL_FRAMES + 1);
    // The hit frame is the first protected frame, so a follow-up hit lands
    // exactly INVULN_FRAMES frames after the one that loaded the timer.
    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES - 1);

    health_state_t    state, state_n;
    logic [2:0]       mask_n;
    logic [6:0]       soul_n;
    logic [FOC_W-1:0] focus_cnt, focus_n;
    logic             respawn_n, heal_done, hit_ok;
    logic             inv_load, inv_dec, inv_zero, death_load, death_zero;
    logic [INV_W-1:0] inv_val, inv_cnt;
    logic [DTH_W-1:0] death_cnt;

    function automatic logic [6:0] soul_next(input logic [6:0] s, input logic gain,
                                             input logic spend);
        logic [7:0] acc;
        acc = {1'b0, s} + (gain ? 8'(SOUL_PER_HIT) : 8'd0);
        if (spend) acc = (acc >= 8'(SOUL_COST)) ? (acc - 8'(SOUL_COST)) : 8'd0;
        if (acc > 8'(SOUL_MAX)) acc = 8'(SOUL_MAX);
        return acc[6:0];
    endfunction

    frame_timer #(.W(INV_W)) u_invuln_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (inv_load),
        .load_val  (inv_val),
        .dec       (inv_dec),
        .count     (inv_cnt),
        .zero      (inv_zero)
    );

    frame_timer #(.W(DTH_W)) u_death_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (death_load),
        .load_val  (DTH_W'(DEATH_FRAMES)),
        .dec       (state == DEAD),
        .count     (death_cnt),
        .zero      (death_zero)
    );

    assign invuln = !inv_zero;
    assign blink  = invuln & inv_cnt[2];
    assign hit_ok = hit_taken && !invuln;

    always_comb begin
        state_n    = state;
        mask_n     = mask_count;
        focus_n    = focus_cnt;
        respawn_n  = 1'b0;
        heal_done  = 1'b0;
        inv_load   = 1'b0;
        inv_val    = INV_LOAD;
        inv_dec    = (state != DEAD);
        death_load = 1'b0;
        case (state)
            ALIVE, FOCUS: begin
                if (hit_ok) begin
                    mask_n   = (mask_count != 3'd0) ? (mask_count - 3'd1) : 3'd0;
                    inv_load = 1'b1;
                    state_n  = ALIVE;
                    if (mask_count <= 3'd1) begin
                        state_n    = DEAD;
                        death_load = 1'b1;
                        inv_val    = '0;
                    end
                end else if (state == ALIVE) begin
                    if (focus_hold && ({1'b0, soul} >= 8'(SOUL_COST)) &&
                        (mask_count < 3'(MAX_MASKS)) && !invuln) begin
                        state_n = FOCUS;
                        focus_n = '0;
                    end
                end else if (!focus_hold) begin
                    state_n = ALIVE;
                end else if (focus_cnt == FOC_W'(HEAL_FRAMES - 1)) begin
                    state_n   = ALIVE;
                    heal_done = 1'b1;
                    mask_n    = (mask_count < 3'(MAX_MASKS)) ? (mask_count + 3'd1) : mask_count;
                end else begin
                    focus_n = focus_cnt + 1'b1;
                end
            end
            DEAD: begin
                // Zero here is unreachable in normal play; treat it as expired too.
                if ((death_cnt == DTH_W'(1)) || death_zero) begin
                    state_n   = ALIVE;
                    mask_n    = 3'(MAX_MASKS);
                    respawn_n = 1'b1;
                    inv_load  = 1'b1;
                end
            end
            default: state_n = ALIVE;
        endcase
        soul_n = respawn_n ? 7'd0 : soul_next(soul, hit_dealt && (state != DEAD), heal_done);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state      <= ALIVE;
            mask_count <= 3'(MAX_MASKS);
            soul       <= 7'd0;
            focus_cnt  <= '0;
            respawn    <= 1'b0;
        end else begin
            state      <= state_n;
            mask_count <= mask_n;
            soul       <= soul_n;
            focus_cnt  <= focus_n;
            respawn    <= respawn_n;
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_MASKS; i++) begin
            mask_on[i] = (3'(i) < mask_count);
        end
    end

    assign healing = (state == FOCUS);
    assign dead    = (state == DEAD);

endmodule

// File: tb/tb_mask_health_ctrl.sv
// Directed scoreboard bench for mask_health_ctrl.
module tb_mask_health_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset, hit_taken, hit_dealt, focus_hold;
    logic [2:0] mask_count;
    logic [4:0] mask_on;
    logic [6:0] soul;
    logic       invuln, blink, healing, dead, respawn;

    typedef enum int {S_MASK, S_MASKON, S_SOUL, S_INV, S_HEAL, S_DEAD, S_RESP} sig_t;
    typedef struct {
        string tag;
        sig_t  sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    mask_health_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .hit_taken  (hit_taken),
        .hit_dealt  (hit_dealt),
        .focus_hold (focus_hold),
        .mask_count (mask_count),
        .mask_on    (mask_on),
        .soul       (soul),
        .invuln     (invuln),
        .blink      (blink),
        .healing    (healing),
        .dead       (dead),
        .respawn    (respawn)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [31:0] observe(sig_t s);
        case (s)
            S_MASK:   return 32'(mask_count);
            S_MASKON: return 32'(mask_on);
            S_SOUL:   return 32'(soul);
            S_INV:    return 32'(invuln);
            S_HEAL:   return 32'(healing);
            S_DEAD:   return 32'(dead);
            default:  return 32'(respawn);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input string tag, input sig_t sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick(input logic h, input logic d, input logic f);
        hit_taken  = h;
        hit_dealt  = d;
        focus_hold = f;
        @(posedge frame_clk);
        #1;
        hit_taken  = 1'b0;
        hit_dealt  = 1'b0;
        focus_hold = 1'b0;
        drain();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        push({tag, "_mask"}, S_MASK, 5);
        push({tag, "_maskon"}, S_MASKON, 31);
        push({tag, "_soul"}, S_SOUL, 0);
        push({tag, "_inv"}, S_INV, 0);
        push({tag, "_heal"}, S_HEAL, 0);
        push({tag, "_dead"}, S_DEAD, 0);
        push({tag, "_resp"}, S_RESP, 0);
        tick(1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        int n;
        int resp_seen;
        Reset = 1'b1; hit_taken = 1'b0; hit_dealt = 1'b0; focus_hold = 1'b0;
        @(posedge frame_clk);
        #1;
        do_reset("rst0");

        // Five hits spaced 61 frames apart, then death and respawn
        for (int k = 1; k <= 5; k++) begin
            push($sformatf("hit%0d_mask", k), S_MASK, 5 - k);
            push($sformatf("hit%0d_maskon", k), S_MASKON, (1 << (5 - k)) - 1);
            push($sformatf("hit%0d_dead", k), S_DEAD, (k == 5) ? 1 : 0);
            push($sformatf("hit%0d_inv", k), S_INV, (k == 5) ? 0 : 1);
            tick(1'b1, 1'b0, 1'b0);
            if (k < 5) idle(60);
        end
        n = 0;
        while (respawn !== 1'b1 && n < 200) begin
            tick(1'b1, 1'b1, 1'b1);
            n++;
        end
        check("respawn_latency", 32'(n), 120);
        check("respawn_mask", 32'(mask_count), 5);
        check("respawn_soul", 32'(soul), 0);
        check("respawn_inv", 32'(invuln), 1);
        check("respawn_dead", 32'(dead), 0);
        push("respawn_pulse_end", S_RESP, 0);
        tick(1'b0, 1'b0, 1'b0);
        idle(60);

        // Hits at frames 0, 30, 60: the middle one falls inside invulnerability
        push("iframe_h0", S_MASK, 4);
        tick(1'b1, 1'b0, 1'b0);
        idle(29);
        push("iframe_h30", S_MASK, 4);
        tick(1'b1, 1'b0, 1'b0);
        idle(29);
        push("iframe_h60", S_MASK, 3);
        tick(1'b1, 1'b0, 1'b0);
        idle(60);

        // Soul build-up and a completed heal
        do_reset("rst1");
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("soul_gain%0d", k), S_SOUL, 11 * k);
            tick(1'b0, 1'b1, 1'b0);
        end
        push("heal_pre_hit", S_MASK, 4);
        tick(1'b1, 1'b0, 1'b0);
        idle(60);
        push("heal_enter", S_HEAL, 1);
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 2; k <= 45; k++) tick(1'b0, 1'b0, 1'b1);
        push("heal_wait_mask", S_MASK, 4);
        push("heal_wait_heal", S_HEAL, 1);
        drain();
        push("heal_done_mask", S_MASK, 5);
        push("heal_done_soul", S_SOUL, 0);
        push("heal_done_heal", S_HEAL, 0);
        tick(1'b0, 1'b0, 1'b1);

        // Released focus and hit-aborted focus
        do_reset("rst2");
        for (int k = 1; k <= 3; k++) tick(1'b0, 1'b1, 1'b0);
        push("abort_pre_hit", S_MASK, 4);
        tick(1'b1, 1'b0, 1'b0);
        idle(60);
        for (int k = 1; k <= 20; k++) tick(1'b0, 1'b0, 1'b1);
        push("release_heal_on", S_HEAL, 1);
        drain();
        push("release_heal", S_HEAL, 0);
        push("release_soul", S_SOUL, 33);
        push("release_mask", S_MASK, 4);
        tick(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) tick(1'b0, 1'b0, 1'b1);
        push("abort_mask", S_MASK, 3);
        push("abort_soul", S_SOUL, 33);
        push("abort_heal", S_HEAL, 0);
        push("abort_dead", S_DEAD, 0);
        tick(1'b1, 1'b0, 1'b1);
        idle(60);

        // Saturation and heal completing together with a hit_dealt
        do_reset("rst3");
        for (int k = 1; k <= 10; k++) begin
            push($sformatf("sat%0d", k), S_SOUL, (k >= 9) ? 99 : 11 * k);
            tick(1'b0, 1'b1, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0);
        idle(60);
        for (int k = 1; k <= 45; k++) tick(1'b0, 1'b0, 1'b1);
        push("heal_hit_soul", S_SOUL, 77);
        push("heal_hit_mask", S_MASK, 5);
        tick(1'b0, 1'b1, 1'b1);

        // Reset while dead at death_timer == 50
        do_reset("rst4");
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (k < 5) idle(60);
        end
        push("dead_before_rst", S_DEAD, 1);
        idle(70);
        do_reset("rst_dead");
        resp_seen = 0;
        for (int k = 0; k < 130; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (respawn === 1'b1) resp_seen++;
        end
        check("no_respawn_after_rst", 32'(resp_seen), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
